// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared encodings for the multicycle CPU control unit.
//   state_t  - FSM state encoding (S_RST = 0)
//   OP_*     - opcode constants (IR[15:12])
//   BC_*     - branch condition codes (IR[11:8])
//   ALU_*    - ALU function select (sel1)
//   ctrl_t   - full control word driven onto the datapath strobes
package cpu_ctrl_pkg;

    // 18 states are needed, so the encoding is 5 bits wide.
    typedef enum logic [4:0] {
        S_RST = 5'd0,
        S_F0, S_F1, S_F2,
        S_I0, S_I1,
        S_DEC,
        S_A0, S_A1, S_A2,
        S_L0, S_L1, S_L2,
        S_M0, S_S1, S_S2,
        S_B0,
        S_HLT
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ALU = 4'h1;
    localparam logic [3:0] OP_LD  = 4'h3;
    localparam logic [3:0] OP_ST  = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h7;
    localparam logic [3:0] OP_BR  = 4'h8;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [3:0] BC_ALW = 4'd0;
    localparam logic [3:0] BC_Z   = 4'd1;
    localparam logic [3:0] BC_C   = 4'd2;
    localparam logic [3:0] BC_S   = 4'd3;
    localparam logic [3:0] BC_V   = 4'd4;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef struct packed {
        logic       mem_rd;
        logic       mem_wr;
        logic       ldbuf;
        logic       ldflags;
        logic       ldpc;
        logic       ld2;
        logic       ldtemp;
        logic       ldmar;
        logic       ldmdr;
        logic       ldir;
        logic       tpc;
        logic       tr2;
        logic       ttemp;
        logic       tmar;
        logic       tmdr2x;
        logic       tmdr;
        logic       add;
        logic       transx;
        logic       rdr;
        logic       wr;
        logic       rmdri;
        logic       rmdrx;
        logic [1:0] sel1;
        logic       halted;
    } ctrl_t;

    // Branch resolution; codes above BC_V are never taken.
    function automatic logic br_taken(input logic [3:0] cond,
                                      input logic s, input logic v,
                                      input logic z, input logic c);
        logic t;
        case (cond)
            BC_ALW:  t = 1'b1;
            BC_Z:    t = z;
            BC_C:    t = c;
            BC_S:    t = s;
            BC_V:    t = v;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/cpu_ctrl_outdec.sv
// cpu_ctrl_outdec: combinational decode of FSM state to the control word.
//   state   in  current FSM state
//   alu_op  in  IR[1:0], used as ALU function in S_A1
//   mem_rdy in  memory done; gates the MDR load in read states
//   ctrl    out control word (every strobe not listed for a state is 0)
module cpu_ctrl_outdec
    import cpu_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [1:0] alu_op,
    input  logic       mem_rdy,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_F0, S_L0: begin
                ctrl.tpc   = 1'b1;
                ctrl.ldmar = 1'b1;
            end
            // Read request held until mem_rdy; MDR captures external data
            // only on the completing cycle.
            S_F1, S_L1: begin
                ctrl.tmar   = 1'b1;
                ctrl.mem_rd = 1'b1;
                if (mem_rdy) begin
                    ctrl.rmdrx = 1'b1;
                    ctrl.ldmdr = 1'b1;
                end
            end
            S_F2: begin
                ctrl.tmdr = 1'b1;
                ctrl.ldir = 1'b1;
            end
            S_I0: begin
                ctrl.tpc   = 1'b1;
                ctrl.ldbuf = 1'b1;
            end
            S_I1: begin
                ctrl.tr2  = 1'b1;
                ctrl.add  = 1'b1;
                ctrl.sel1 = ALU_ADD;
                ctrl.ldpc = 1'b1;
            end
            S_A0: begin
                ctrl.rdr = 1'b1;
                ctrl.ld2 = 1'b1;
            end
            S_A1: begin
                ctrl.rdr     = 1'b1;
                ctrl.transx  = 1'b1;
                ctrl.add     = 1'b1;
                ctrl.sel1    = alu_op;
                ctrl.ldtemp  = 1'b1;
                ctrl.ldflags = 1'b1;
            end
            S_A2: begin
                ctrl.ttemp  = 1'b1;
                ctrl.transx = 1'b1;
                ctrl.wr     = 1'b1;
            end
            S_L2: begin
                ctrl.tmdr2x = 1'b1;
                ctrl.transx = 1'b1;
                ctrl.wr     = 1'b1;
            end
            S_M0: begin
                ctrl.rdr   = 1'b1;
                ctrl.ldmar = 1'b1;
            end
            S_S1: begin
                ctrl.rdr    = 1'b1;
                ctrl.transx = 1'b1;
                ctrl.rmdri  = 1'b1;
                ctrl.ldmdr  = 1'b1;
            end
            S_S2: begin
                ctrl.tmar   = 1'b1;
                ctrl.tmdr   = 1'b1;
                ctrl.mem_wr = 1'b1;
            end
            S_B0: begin
                ctrl.rdr  = 1'b1;
                ctrl.ldpc = 1'b1;
            end
            S_HLT: ctrl.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multicycle control FSM for CPUdatapath.
//   clk, rst              clock, synchronous active-high reset
//   IRout                 instruction register contents
//   Sout/Vout/Zout/Cout   latched datapath flags (branch conditions)
//   mem_rdy               memory handshake completion
//   mem_rd, mem_wr        memory request, held until mem_rdy
//   ld*, T*, add, transx,
//   rdR, wR, rMDRi, rMDRX,
//   sel1                  datapath strobes (decoded in cpu_ctrl_outdec)
//   halted                high while parked in S_HLT
module cpu_control_unit
    import cpu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] IRout,
    input  logic        Sout,
    input  logic        Vout,
    input  logic        Zout,
    input  logic        Cout,
    input  logic        mem_rdy,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        ldbuf,
    output logic        ldflags,
    output logic        ldPC,
    output logic        ld2,
    output logic        ldtemp,
    output logic        ldMAR,
    output logic        ldMDR,
    output logic        ldIR,
    output logic        TPC,
    output logic        Tr2,
    output logic        Ttemp,
    output logic        TMAR,
    output logic        TMDR2X,
    output logic        TMDR,
    output logic        add,
    output logic        transx,
    output logic        rdR,
    output logic        wR,
    output logic        rMDRi,
    output logic        rMDRX,
    output logic [1:0]  sel1,
    output logic        halted
);

    state_t state_q, state_d;
    // Set while executing LDI: the PC-increment pair after S_L2 must
    // return to fetch instead of falling into decode again.
    logic   ldi_ret_q, ldi_ret_d;
    ctrl_t  ctrl;

    logic [3:0] opcode;
    logic [3:0] cond;
    assign opcode = IRout[15:12];
    assign cond   = IRout[11:8];

    // rd/rs fields are consumed by the datapath, not by this block.
    logic ir_unused;
    assign ir_unused = ^IRout[7:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_RST;
            ldi_ret_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ldi_ret_q <= ldi_ret_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ldi_ret_d = ldi_ret_q;
        case (state_q)
            S_RST: state_d = S_F0;
            S_F0:  state_d = S_F1;
            S_F1:  if (mem_rdy) state_d = S_F2;
            S_F2:  state_d = S_I0;
            S_I0:  state_d = S_I1;
            S_I1: begin
                if (ldi_ret_q) begin
                    state_d   = S_F0;
                    ldi_ret_d = 1'b0;
                end else begin
                    state_d = S_DEC;
                end
            end
            S_DEC: begin
                case (opcode)
                    OP_ALU: state_d = S_A0;
                    OP_LDI: begin
                        state_d   = S_L0;
                        ldi_ret_d = 1'b1;
                    end
                    OP_LD, OP_ST: state_d = S_M0;
                    OP_BR: state_d = br_taken(cond, Sout, Vout, Zout, Cout)
                                     ? S_B0 : S_F0;
                    OP_HLT: state_d = S_HLT;
                    default: state_d = S_F0;
                endcase
            end
            S_A0: state_d = S_A1;
            S_A1: state_d = S_A2;
            S_A2: state_d = S_F0;
            S_L0: state_d = S_L1;
            S_L1: if (mem_rdy) state_d = S_L2;
            S_L2: state_d = ldi_ret_q ? S_I0 : S_F0;
            // S_M0 is shared by LD and ST; IR is stable so re-decode here.
            S_M0: state_d = (opcode == OP_ST) ? S_S1 : S_L1;
            S_S1: state_d = S_S2;
            S_S2: if (mem_rdy) state_d = S_F0;
            S_B0: state_d = S_F0;
            S_HLT: state_d = S_HLT;
            default: state_d = S_RST;
        endcase
    end

    cpu_ctrl_outdec u_outdec (
        .state   (state_q),
        .alu_op  (IRout[1:0]),
        .mem_rdy (mem_rdy),
        .ctrl    (ctrl)
    );

    assign mem_rd  = ctrl.mem_rd;
    assign mem_wr  = ctrl.mem_wr;
    assign ldbuf   = ctrl.ldbuf;
    assign ldflags = ctrl.ldflags;
    assign ldPC    = ctrl.ldpc;
    assign ld2     = ctrl.ld2;
    assign ldtemp  = ctrl.ldtemp;
    assign ldMAR   = ctrl.ldmar;
    assign ldMDR   = ctrl.ldmdr;
    assign ldIR    = ctrl.ldir;
    assign TPC     = ctrl.tpc;
    assign Tr2     = ctrl.tr2;
    assign Ttemp   = ctrl.ttemp;
    assign TMAR    = ctrl.tmar;
    assign TMDR2X  = ctrl.tmdr2x;
    assign TMDR    = ctrl.tmdr;
    assign add     = ctrl.add;
    assign transx  = ctrl.transx;
    assign rdR     = ctrl.rdr;
    assign wR      = ctrl.wr;
    assign rMDRi   = ctrl.rmdri;
    assign rMDRX   = ctrl.rmdrx;
    assign sel1    = ctrl.sel1;
    assign halted  = ctrl.halted;

endmodule
